// File: rtl/id_stage_fwd_pkg.sv
// Shared encodings for the decode stage: immediate formats, writeback select,
// and the register-index width helper.
package id_stage_fwd_pkg;

    typedef enum logic [2:0] {
        SEXT_I    = 3'd0,
        SEXT_S    = 3'd1,
        SEXT_B    = 3'd2,
        SEXT_U    = 3'd3,
        SEXT_J    = 3'd4,
        SEXT_NONE = 3'd5
    } sext_e;

    typedef enum logic [1:0] {
        RF_WSEL_ALU = 2'd0,
        RF_WSEL_PC4 = 2'd1,
        RF_WSEL_EXT = 2'd2,
        RF_WSEL_RDO = 2'd3
    } rf_wsel_e;

    // Register-index width; a one-entry file still needs a one-bit index.
    function automatic int rw_bits(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/id_stage_fwd_rf_bypass.sv
// Two-read / one-write register file; a read of the register being written this
// cycle returns the incoming write data. Register 0 always reads zero.
module rf_bypass
    import id_stage_fwd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW = rw_bits(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [RW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [RW-1:0]   ra1_i,
    input  logic [RW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && wa_i != '0 && int'(wa_i) < NREG) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = '0;
        if (ra1_i != '0 && int'(ra1_i) < NREG) begin
            if (we_i && wa_i == ra1_i) rd1_o = wd_i;
            else                       rd1_o = regs_q[ra1_i];
        end
    end

    always_comb begin
        rd2_o = '0;
        if (ra2_i != '0 && int'(ra2_i) < NREG) begin
            if (we_i && wa_i == ra2_i) rd2_o = wd_i;
            else                       rd2_o = regs_q[ra2_i];
        end
    end

endmodule

// File: rtl/id_stage_fwd.sv
// RV32 decode stage: immediate extension, forwarded operand read, load-use
// hazard detection and the registered ID/EX boundary.
module id_stage_fwd
    import id_stage_fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter bit FWD_EN = 1'b1,
    localparam int RW = rw_bits(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pc4,
    input  logic [2:0]      sext_op,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            rd_we,
    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [RW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_alu_c,
    input  logic            mem_we,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_wd,
    input  logic            wb_we,
    input  logic [RW-1:0]   wb_rd,
    input  logic [1:0]      wb_wsel,
    input  logic [XLEN-1:0] wb_alu_c,
    input  logic [XLEN-1:0] wb_pc4,
    input  logic [XLEN-1:0] wb_ext,
    input  logic [XLEN-1:0] wb_rdo,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            id_stall,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [XLEN-1:0] idex_pc4,
    output logic [XLEN-1:0] idex_rD1,
    output logic [XLEN-1:0] idex_rD2,
    output logic [XLEN-1:0] idex_ext,
    output logic [RW-1:0]   idex_rd,
    output logic            idex_we,
    output logic [XLEN-1:0] rf_wD
);

    logic [RW-1:0]   rs1, rs2, rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rf_rd1, rf_rd2, opnd1, opnd2;
    logic            match_ex, match_mem, haz;
    logic            unused_inst;

    assign rs1 = RW'(if_inst[19:15]);
    assign rs2 = RW'(if_inst[24:20]);
    assign rd  = RW'(if_inst[11:7]);
    assign unused_inst = ^if_inst[6:0];

    always_comb begin
        imm32 = '0;
        case (sext_op)
            SEXT_I:  imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
            SEXT_S:  imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            SEXT_B:  imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                              if_inst[30:25], if_inst[11:8], 1'b0};
            SEXT_U:  imm32 = {if_inst[31:12], 12'b0};
            SEXT_J:  imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                              if_inst[20], if_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end
    assign imm = XLEN'($signed(imm32));

    always_comb begin
        rf_wD = wb_alu_c;
        case (wb_wsel)
            RF_WSEL_ALU: rf_wD = wb_alu_c;
            RF_WSEL_PC4: rf_wD = wb_pc4;
            RF_WSEL_EXT: rf_wD = wb_ext;
            default:     rf_wD = wb_rdo;
        endcase
    end

    rf_bypass #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk_i (clk),
        .rst_i (rst),
        .we_i  (wb_we),
        .wa_i  (wb_rd),
        .wd_i  (rf_wD),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2)
    );

    // A load's EX value is its address, never its data, so loads are not forwarded from EX.
    always_comb begin
        opnd1 = rf_rd1;
        if (rs1 != '0) begin
            if (FWD_EN && ex_valid && ex_we && !ex_is_load && ex_rd == rs1) opnd1 = ex_alu_c;
            else if (FWD_EN && mem_we && mem_rd == rs1)                    opnd1 = mem_wd;
        end
    end

    always_comb begin
        opnd2 = rf_rd2;
        if (rs2 != '0) begin
            if (FWD_EN && ex_valid && ex_we && !ex_is_load && ex_rd == rs2) opnd2 = ex_alu_c;
            else if (FWD_EN && mem_we && mem_rd == rs2)                    opnd2 = mem_wd;
        end
    end

    assign match_ex  = (ex_rd != '0) &&
                       ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));
    assign match_mem = (mem_rd != '0) &&
                       ((rs1_used && rs1 == mem_rd) || (rs2_used && rs2 == mem_rd));

    // Without forwarding, any pending EX or MEM write to a source must drain to WB first.
    assign haz = if_valid &&
                 ((ex_valid && ex_we && match_ex && (ex_is_load || !FWD_EN)) ||
                  (!FWD_EN && mem_we && match_mem));

    assign id_stall = haz || ex_stall;

    logic            valid_q, we_q;
    logic [XLEN-1:0] pc_q, pc4_q, rd1_q, rd2_q, ext_q;
    logic [RW-1:0]   rd_q;

    // idex_valid marks a real instruction in ID/EX; a bubble has valid=0 and we=0,
    // and its data fields are stale and must be ignored by EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ext_q   <= '0;
            rd_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (ex_stall) begin
            valid_q <= valid_q;
        end else if (haz) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            valid_q <= if_valid;
            we_q    <= rd_we && if_valid && (rd != '0);
            pc_q    <= if_pc;
            pc4_q   <= if_pc4;
            rd1_q   <= opnd1;
            rd2_q   <= opnd2;
            ext_q   <= imm;
            rd_q    <= rd;
        end
    end

    assign idex_valid = valid_q;
    assign idex_we    = we_q;
    assign idex_pc    = pc_q;
    assign idex_pc4   = pc4_q;
    assign idex_rD1   = rd1_q;
    assign idex_rD2   = rd2_q;
    assign idex_ext   = ext_q;
    assign idex_rd    = rd_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: a forwarding build checked through an expected queue,
// plus a non-forwarding build checked directly for its stall behaviour.
`timescale 1ns/1ps
module tb_id_stage_fwd;
    import id_stage_fwd_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            if_valid = 1'b0;
    logic [31:0]     if_inst = '0;
    logic [XLEN-1:0] if_pc = '0, if_pc4 = '0;
    logic [2:0]      sext_op = '0;
    logic            rs1_used = 1'b0, rs2_used = 1'b0, rd_we = 1'b0;
    logic            ex_valid = 1'b0, ex_we = 1'b0, ex_is_load = 1'b0;
    logic [RW-1:0]   ex_rd = '0, mem_rd = '0, wb_rd = '0;
    logic [XLEN-1:0] ex_alu_c = '0, mem_wd = '0;
    logic            mem_we = 1'b0, wb_we = 1'b0;
    logic [1:0]      wb_wsel = '0;
    logic [XLEN-1:0] wb_alu_c = '0, wb_pc4 = '0, wb_ext = '0, wb_rdo = '0;
    logic            ex_stall = 1'b0, flush = 1'b0;

    logic            id_stall, idex_valid, idex_we;
    logic [XLEN-1:0] idex_pc, idex_pc4, idex_rD1, idex_rD2, idex_ext, rf_wD;
    logic [RW-1:0]   idex_rd;

    logic            id_stall_nf, idex_valid_nf, idex_we_nf;
    logic [XLEN-1:0] idex_pc_nf, idex_pc4_nf, idex_rD1_nf, idex_rD2_nf, idex_ext_nf, rf_wD_nf;
    logic [RW-1:0]   idex_rd_nf;

    always #5 clk = ~clk;

    id_stage_fwd #(.XLEN(XLEN), .NREG(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_pc4(if_pc4), .sext_op(sext_op), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_we(rd_we), .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_alu_c(ex_alu_c), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_wd(mem_wd), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wsel(wb_wsel),
        .wb_alu_c(wb_alu_c), .wb_pc4(wb_pc4), .wb_ext(wb_ext), .wb_rdo(wb_rdo),
        .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .idex_valid(idex_valid),
        .idex_pc(idex_pc), .idex_pc4(idex_pc4), .idex_rD1(idex_rD1), .idex_rD2(idex_rD2),
        .idex_ext(idex_ext), .idex_rd(idex_rd), .idex_we(idex_we), .rf_wD(rf_wD)
    );

    id_stage_fwd #(.XLEN(XLEN), .NREG(32), .FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_pc4(if_pc4), .sext_op(sext_op), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_we(rd_we), .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_alu_c(ex_alu_c), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_wd(mem_wd), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wsel(wb_wsel),
        .wb_alu_c(wb_alu_c), .wb_pc4(wb_pc4), .wb_ext(wb_ext), .wb_rdo(wb_rdo),
        .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall_nf), .idex_valid(idex_valid_nf),
        .idex_pc(idex_pc_nf), .idex_pc4(idex_pc4_nf), .idex_rD1(idex_rD1_nf),
        .idex_rD2(idex_rD2_nf), .idex_ext(idex_ext_nf), .idex_rd(idex_rd_nf),
        .idex_we(idex_we_nf), .rf_wD(rf_wD_nf)
    );

    typedef struct packed {
        logic            valid;
        logic            we;
        logic            chk_data;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] ext;
    } exp_t;

    exp_t            exp_q[$];
    logic [XLEN-1:0] model_rf [32];
    int              n_checks = 0;
    int              n_errors = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        return {7'b0, r2, r1, 3'b0, rd, 7'h33};
    endfunction

    function automatic logic [XLEN-1:0] imm_model(input logic [31:0] i, input logic [2:0] op);
        logic [31:0] r;
        case (op)
            3'd0:    r = {{20{i[31]}}, i[31:20]};
            3'd1:    r = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    r = {i[31:12], 12'b0};
            3'd4:    r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] wd_model();
        case (wb_wsel)
            2'd0:    return wb_alu_c;
            2'd1:    return wb_pc4;
            2'd2:    return wb_ext;
            default: return wb_rdo;
        endcase
    endfunction

    // Value the ID stage should read for rs when nothing is pending in EX/MEM.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] rs);
        if (rs == 5'd0) return '0;
        if (wb_we && wb_rd == rs) return wd_model();
        return model_rf[rs];
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [2:0] sop, input logic u1,
                         input logic u2, input logic we, input logic [XLEN-1:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        sext_op  = sop;
        rs1_used = u1;
        rs2_used = u2;
        rd_we    = we;
        if_pc    = pc;
        if_pc4   = pc + 32'd4;
    endtask

    task automatic clear_side();
        ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_alu_c = '0;
        mem_we = 1'b0; mem_rd = '0; mem_wd = '0;
        wb_we = 1'b0; wb_rd = '0; wb_wsel = '0;
        ex_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input logic v, input logic we, input logic chk, input logic [RW-1:0] rd,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pc4,
                        input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                        input logic [XLEN-1:0] ext);
        exp_t e;
        e.valid = v; e.we = we; e.chk_data = chk; e.rd = rd;
        e.pc = pc; e.pc4 = pc4; e.rd1 = rd1; e.rd2 = rd2; e.ext = ext;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop();
        exp_t e;
        e = exp_q.pop_front();
        check("idex_valid", XLEN'(idex_valid), XLEN'(e.valid));
        check("idex_we", XLEN'(idex_we), XLEN'(e.we));
        if (e.chk_data) begin
            check("idex_rd", XLEN'(idex_rd), XLEN'(e.rd));
            check("idex_pc", idex_pc, e.pc);
            check("idex_pc4", idex_pc4, e.pc4);
            check("idex_rD1", idex_rD1, e.rd1);
            check("idex_rD2", idex_rD2, e.rd2);
            check("idex_ext", idex_ext, e.ext);
        end
    endtask

    // One clock: track the architectural RF, then compare the registered outputs.
    task automatic step();
        logic [XLEN-1:0] wd;
        logic            do_wr, do_rst;
        logic [4:0]      wr_idx;
        wd     = wd_model();
        do_wr  = wb_we;
        wr_idx = wb_rd;
        do_rst = rst;
        @(posedge clk);
        if (do_rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] = '0;
        end else if (do_wr && wr_idx != 5'd0) begin
            model_rf[wr_idx] = wd;
        end
        #1;
        if (exp_q.size() > 0) sb_pop();
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [31:0] inst;
        logic [2:0]  sop;
        logic        we;
        logic [4:0]  r1, r2;
        logic [XLEN-1:0] e1, e2;

        for (int i = 0; i < 32; i++) model_rf[i] = '0;

        // Reset held two cycles with a valid instruction presented.
        rst = 1'b1;
        drive(mk_r(5'd1, 5'd2, 5'd3), 3'(SEXT_I), 1'b1, 1'b1, 1'b1, 32'h40);
        push(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0, '0);
        step();
        push(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0, '0);
        step();
        rst = 1'b0;

        for (int r = 0; r < 32; r++) begin
            drive(mk_r(5'd0, 5'(r), 5'(31 - r)), 3'(SEXT_NONE), 1'b1, 1'b1, 1'b0, XLEN'(r * 4));
            push(1'b1, 1'b0, 1'b1, '0, XLEN'(r * 4), XLEN'(r * 4 + 4), '0, '0, '0);
            step();
        end

        // Immediates
        drive(32'hFFF00093, 3'(SEXT_I), 1'b1, 1'b0, 1'b1, 32'h100);
        push(1'b1, 1'b1, 1'b1, 5'd1, 32'h100, 32'h104, '0, '0, 32'hFFFFFFFF);
        step();
        drive(32'h800000EF, 3'(SEXT_J), 1'b0, 1'b0, 1'b1, 32'h104);
        push(1'b1, 1'b1, 1'b1, 5'd1, 32'h104, 32'h108, '0, '0, 32'hFFF00000);
        step();
        for (int k = 0; k < 24; k++) begin
            inst = $urandom;
            sop  = 3'($urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            drive(inst, sop, 1'b0, 1'b0, we, XLEN'(32'h1000 + k * 4));
            push(1'b1, we && (inst[11:7] != 5'd0), 1'b1, inst[11:7], XLEN'(32'h1000 + k * 4),
                 XLEN'(32'h1004 + k * 4), '0, '0, imm_model(inst, sop));
            step();
        end

        // Write-first bypass and the writeback mux
        wb_we = 1'b1; wb_rd = 5'd5; wb_wsel = 2'(RF_WSEL_ALU); wb_alu_c = 32'h1234;
        drive(mk_r(5'd0, 5'd5, 5'd0), 3'(SEXT_NONE), 1'b1, 1'b0, 1'b0, 32'h180);
        settle();
        check("rf_wD_alu", rf_wD, 32'h1234);
        push(1'b1, 1'b0, 1'b1, '0, 32'h180, 32'h184, 32'h1234, '0, '0);
        step();
        wb_rd = 5'd0; wb_wsel = 2'(RF_WSEL_PC4); wb_pc4 = 32'hDEAD;
        drive(mk_r(5'd0, 5'd0, 5'd5), 3'(SEXT_NONE), 1'b1, 1'b1, 1'b0, 32'h184);
        settle();
        check("rf_wD_pc4", rf_wD, 32'hDEAD);
        push(1'b1, 1'b0, 1'b1, '0, 32'h184, 32'h188, '0, 32'h1234, '0);
        step();
        wb_we = 1'b0;
        wb_wsel = 2'(RF_WSEL_EXT); wb_ext = 32'h5EED;
        settle();
        check("rf_wD_ext", rf_wD, 32'h5EED);
        wb_wsel = 2'(RF_WSEL_RDO); wb_rdo = 32'hF00D;
        settle();
        check("rf_wD_rdo", rf_wD, 32'hF00D);

        // Random RF traffic with write-first reads
        for (int k = 0; k < 40; k++) begin
            wb_we    = 1'($urandom_range(0, 1));
            wb_rd    = 5'($urandom_range(0, 31));
            wb_wsel  = 2'($urandom_range(0, 3));
            wb_alu_c = $urandom; wb_pc4 = $urandom; wb_ext = $urandom; wb_rdo = $urandom;
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            drive(mk_r(5'd0, r1, r2), 3'(SEXT_NONE), 1'b1, 1'b1, 1'b0, XLEN'(32'h2000 + k * 4));
            e1 = rf_read(r1);
            e2 = rf_read(r2);
            push(1'b1, 1'b0, 1'b1, '0, XLEN'(32'h2000 + k * 4), XLEN'(32'h2004 + k * 4), e1, e2, '0);
            step();
        end
        clear_side();

        // Forwarding priority EX > MEM > WB
        ex_valid = 1'b1; ex_we = 1'b1; ex_rd = 5'd3; ex_alu_c = 32'hAAAA;
        mem_we = 1'b1; mem_rd = 5'd3; mem_wd = 32'hBBBB;
        wb_we = 1'b1; wb_rd = 5'd3; wb_wsel = 2'(RF_WSEL_ALU); wb_alu_c = 32'hCCCC;
        drive(mk_r(5'd0, 5'd0, 5'd3), 3'(SEXT_NONE), 1'b0, 1'b1, 1'b0, 32'h200);
        settle();
        check("fwd_no_stall", XLEN'(id_stall), 32'd0);
        push(1'b1, 1'b0, 1'b1, '0, 32'h200, 32'h204, '0, 32'hAAAA, '0);
        step();
        ex_we = 1'b0;
        push(1'b1, 1'b0, 1'b1, '0, 32'h200, 32'h204, '0, 32'hBBBB, '0);
        step();
        mem_we = 1'b0;
        push(1'b1, 1'b0, 1'b1, '0, 32'h200, 32'h204, '0, 32'hCCCC, '0);
        step();
        clear_side();

        // Load-use: one bubble, then the loaded value arrives from MEM
        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; ex_alu_c = 32'h999;
        drive(mk_r(5'd8, 5'd7, 5'd0), 3'(SEXT_NONE), 1'b1, 1'b0, 1'b1, 32'h300);
        settle();
        check("lu_stall", XLEN'(id_stall), 32'd1);
        push(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
        step();
        ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0;
        mem_we = 1'b1; mem_rd = 5'd7; mem_wd = 32'h55;
        settle();
        check("lu_release", XLEN'(id_stall), 32'd0);
        push(1'b1, 1'b1, 1'b1, 5'd8, 32'h300, 32'h304, 32'h55, '0, '0);
        step();
        clear_side();
        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        drive(mk_r(5'd8, 5'd7, 5'd0), 3'(SEXT_NONE), 1'b0, 1'b0, 1'b1, 32'h308);
        settle();
        check("lu_unused_src", XLEN'(id_stall), 32'd0);
        push(1'b1, 1'b1, 1'b1, 5'd8, 32'h308, 32'h30C, model_rf[7], '0, '0);
        step();
        clear_side();

        // ex_stall holds ID/EX for three cycles
        drive(32'h7FF00513, 3'(SEXT_I), 1'b1, 1'b0, 1'b1, 32'h400);
        push(1'b1, 1'b1, 1'b1, 5'd10, 32'h400, 32'h404, '0, model_rf[31], 32'h7FF);
        step();
        ex_stall = 1'b1;
        drive(mk_r(5'd11, 5'd1, 5'd2), 3'(SEXT_NONE), 1'b1, 1'b1, 1'b1, 32'h404);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("stall_out", XLEN'(id_stall), 32'd1);
            push(1'b1, 1'b1, 1'b1, 5'd10, 32'h400, 32'h404, '0, model_rf[31], 32'h7FF);
            step();
        end
        ex_stall = 1'b0;
        push(1'b1, 1'b1, 1'b1, 5'd11, 32'h404, 32'h408, model_rf[1], model_rf[2], '0);
        step();

        // Flush together with a load-use hazard
        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12;
        drive(mk_r(5'd13, 5'd12, 5'd0), 3'(SEXT_NONE), 1'b1, 1'b0, 1'b1, 32'h500);
        flush = 1'b1;
        settle();
        check("flush_haz_stall", XLEN'(id_stall), 32'd1);
        push(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
        step();
        clear_side();
        push(1'b1, 1'b1, 1'b1, 5'd13, 32'h500, 32'h504, model_rf[12], '0, '0);
        step();
        flush = 1'b1;
        drive(mk_r(5'd14, 5'd0, 5'd0), 3'(SEXT_NONE), 1'b0, 1'b0, 1'b1, 32'h508);
        settle();
        check("flush_no_stall", XLEN'(id_stall), 32'd0);
        push(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
        step();
        flush = 1'b0;
        if_valid = 1'b0;
        push(1'b0, 1'b0, 1'b1, 5'd14, 32'h508, 32'h50C, '0, '0, '0);
        step();

        // Non-forwarding build: an ALU RAW waits until the value reaches WB
        clear_side();
        ex_valid = 1'b1; ex_we = 1'b1; ex_rd = 5'd9; ex_alu_c = 32'h77;
        drive(mk_r(5'd15, 5'd9, 5'd0), 3'(SEXT_NONE), 1'b1, 1'b0, 1'b1, 32'h600);
        settle();
        check("nf_stall_ex", XLEN'(id_stall_nf), 32'd1);
        check("fwd_stall_ex", XLEN'(id_stall), 32'd0);
        push(1'b1, 1'b1, 1'b1, 5'd15, 32'h600, 32'h604, 32'h77, '0, '0);
        step();
        check("nf_bubble_ex", XLEN'(idex_valid_nf), 32'd0);
        ex_valid = 1'b0; ex_we = 1'b0;
        mem_we = 1'b1; mem_rd = 5'd9; mem_wd = 32'h77;
        settle();
        check("nf_stall_mem", XLEN'(id_stall_nf), 32'd1);
        push(1'b1, 1'b1, 1'b1, 5'd15, 32'h600, 32'h604, 32'h77, '0, '0);
        step();
        check("nf_bubble_mem", XLEN'(idex_valid_nf), 32'd0);
        mem_we = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd9; wb_wsel = 2'(RF_WSEL_ALU); wb_alu_c = 32'h77;
        settle();
        check("nf_release_wb", XLEN'(id_stall_nf), 32'd0);
        push(1'b1, 1'b1, 1'b1, 5'd15, 32'h600, 32'h604, 32'h77, '0, '0);
        step();
        check("nf_valid", XLEN'(idex_valid_nf), 32'd1);
        check("nf_rD1", idex_rD1_nf, 32'h77);
        check("nf_we", XLEN'(idex_we_nf), 32'd1);
        clear_side();

        // Reset in the middle of a stall leaves no residual bubble
        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        drive(mk_r(5'd16, 5'd7, 5'd0), 3'(SEXT_NONE), 1'b1, 1'b0, 1'b1, 32'h700);
        settle();
        check("rst_pre_stall", XLEN'(id_stall), 32'd1);
        rst = 1'b1;
        push(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0, '0);
        step();
        rst = 1'b0;
        clear_side();
        drive(mk_r(5'd16, 5'd5, 5'd0), 3'(SEXT_NONE), 1'b1, 1'b0, 1'b1, 32'h704);
        push(1'b1, 1'b1, 1'b1, 5'd16, 32'h704, 32'h708, model_rf[5], '0, '0);
        step();

        check("sb_drain", XLEN'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
